// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory interface: access widths, FSM states
// and the latched bus command.
package dmem_pkg;

  localparam logic [2:0] WIDTH_W  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b010;
  localparam logic [2:0] WIDTH_HU = 3'b110;
  localparam logic [2:0] WIDTH_B  = 3'b001;
  localparam logic [2:0] WIDTH_BU = 3'b101;

  // Low two width bits select the access size; bit 2 only marks unsigned loads.
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_cmd_t;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and the
// misalignment flag for one M-stage access.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wd,
  input  logic        is_read,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b1111;
    wdata      = wd;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{wd[7:0]}};
      end
      SIZE_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{wd[15:0]}};
        misaligned = offset[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = wd;
        misaligned = |offset;
      end
    endcase
    // Loads always fetch the whole word; the memory stage extracts the lane.
    if (is_read) begin
      be = 4'b1111;
    end
  end

endmodule

// File: rtl/data_mem_interface.sv
// Data-side bus master below the M stage: issues one req/gnt/rvalid transaction
// per load/store, stalls the pipeline until it completes, and times out stuck accesses.
module data_mem_interface
  import dmem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_m_i,
  input  logic        mem_read_m_i,
  input  logic        mem_write_m_i,
  input  logic [2:0]  width_src_m_i,
  input  logic [31:0] alu_result_m_i,
  input  logic [31:0] write_data_m_i,
  output logic [31:0] read_data_m_o,
  output logic        stall_req_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output dmem_state_t state_o
);

  localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  bus_cmd_t         cmd_q, cmd_now, cmd_out;
  logic [31:0]      rdata_q;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        misaligned;
  logic        mem_op, access, timed_out;
  logic        req, stall, mis_pulse, err_pulse;
  logic        unused_width_sign;

  assign unused_width_sign = width_src_m_i[2];

  dmem_lane_align u_lane_align (
    .size       (width_src_m_i[1:0]),
    .offset     (alu_result_m_i[1:0]),
    .wd         (write_data_m_i),
    .is_read    (mem_read_m_i),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .misaligned (misaligned)
  );

  assign mem_op    = valid_m_i & (mem_read_m_i | mem_write_m_i);
  assign access    = mem_op & ~misaligned;
  assign timed_out = (cnt_q >= CNT_LAST);

  always_comb begin
    cmd_now.we    = ~mem_read_m_i & mem_write_m_i;
    cmd_now.addr  = word_addr(alu_result_m_i);
    cmd_now.be    = lane_be;
    cmd_now.wdata = lane_wdata;
  end

  // Handshake: a request is accepted in any cycle where bus_req_o and bus_gnt_i
  // are both high; the command must then stay stable until that cycle. Read
  // data is taken in any WAIT cycle with bus_rvalid_i high (never the gnt cycle).
  // A completion event in the same cycle as the timeout wins over the timeout.
  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    stall     = 1'b0;
    mis_pulse = 1'b0;
    err_pulse = 1'b0;
    cmd_out   = cmd_q;
    case (state_q)
      S_IDLE: begin
        mis_pulse = mem_op & misaligned;
        if (access) begin
          req     = 1'b1;
          stall   = 1'b1;
          cmd_out = cmd_now;
          if (bus_gnt_i) begin
            state_d = cmd_now.we ? S_DONE : S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (bus_gnt_i) begin
          state_d = cmd_q.we ? S_DONE : S_WAIT;
        end else if (timed_out) begin
          err_pulse = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid_i) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          err_pulse = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset must drop the request in the same cycle, not one edge later.
    if (reset_i) begin
      state_d   = S_IDLE;
      req       = 1'b0;
      stall     = 1'b0;
      mis_pulse = 1'b0;
      err_pulse = 1'b0;
      cmd_out   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (access) begin
          cmd_q <= cmd_now;
        end
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == S_WAIT) && bus_rvalid_i) begin
        rdata_q <= bus_rdata_i;
      end else if (err_pulse) begin
        rdata_q <= '0;
      end
    end
  end

  assign read_data_m_o = rdata_q;
  assign stall_req_o   = stall;
  assign misalign_o    = mis_pulse;
  assign bus_err_o     = err_pulse;
  assign bus_req_o     = req;
  assign bus_we_o      = cmd_out.we;
  assign bus_addr_o    = cmd_out.addr;
  assign bus_be_o      = cmd_out.be;
  assign bus_wdata_o   = cmd_out.wdata;
  assign state_o       = state_q;

endmodule

// File: tb/tb_data_mem_interface.sv
// Bench for data_mem_interface: directed corner cases plus randomized loads/stores
// against a transaction-level reference model, checked by a decoupled monitor.
module tb_data_mem_interface;
  import dmem_pkg::*;

  localparam int T        = 4;
  localparam int LOOP_MAX = 100;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_m_i, mem_read_m_i, mem_write_m_i;
  logic [2:0]  width_src_m_i;
  logic [31:0] alu_result_m_i, write_data_m_i;
  logic [31:0] read_data_m_o;
  logic        stall_req_o, misalign_o, bus_err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  dmem_state_t state_o;

  data_mem_interface #(.BUS_TIMEOUT(T)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .valid_m_i      (valid_m_i),
    .mem_read_m_i   (mem_read_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .width_src_m_i  (width_src_m_i),
    .alu_result_m_i (alu_result_m_i),
    .write_data_m_i (write_data_m_i),
    .read_data_m_o  (read_data_m_o),
    .stall_req_o    (stall_req_o),
    .misalign_o     (misalign_o),
    .bus_err_o      (bus_err_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_be_o       (bus_be_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i),
    .state_o        (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        mis;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  stalls;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  rd_model = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int size_of(input logic [2:0] w);
    case (w)
      WIDTH_B, WIDTH_BU: return 1;
      WIDTH_H, WIDTH_HU: return 2;
      default:           return 4;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] wd, input int n);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  // ---------------- driver ----------------
  // Presents one M-stage instruction plus the bus slave's behaviour for it:
  // grant g cycles after the instruction appears, read data r cycles after grant.
  task automatic issue(input logic v, input logic rd, input logic wr, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] wd, input int g, input int r,
                       input logic [31:0] rdat, input logic scramble);
    exp_t e;
    int   n, k, off;
    logic done;
    valid_m_i      = v;
    mem_read_m_i   = rd;
    mem_write_m_i  = wr;
    width_src_m_i  = w;
    alu_result_m_i = a;
    write_data_m_i = wd;
    if (v && (rd || wr)) begin
      n   = size_of(w);
      off = int'(a[1:0]);
      e   = '0;
      if ((off % n) != 0) begin
        e.mis = 1'b1;
      end else begin
        e.we    = !rd;
        e.addr  = a & 32'hFFFF_FFFC;
        e.be    = rd ? 4'hF : 4'(((1 << n) - 1) << off);
        e.wdata = replicate(wd, n);
        if (g > T) begin
          e.err    = 1'b1;
          e.stalls = 8'(T + 1);
        end else if (!rd) begin
          e.stalls = 8'(g + 1);
        end else begin
          k = (T > g + 1) ? T : g + 1;
          if (g + r <= k) begin
            e.stalls = 8'(g + r + 1);
            rd_model = rdat;
          end else begin
            e.err    = 1'b1;
            e.stalls = 8'(k + 1);
          end
        end
        if (e.err) rd_model = 32'h0;
        e.rdata = rd_model;
      end
      exp_q.push_back(e);
    end
    done = 1'b0;
    for (int c = 0; c < LOOP_MAX; c++) begin
      @(negedge clk_i);
      bus_gnt_i    = (c == g) && bus_req_o;
      bus_rvalid_i = (c == g + r) || ((c <= g) && ($urandom_range(0, 3) == 0));
      bus_rdata_i  = (c == g + r) ? rdat : $urandom();
      done         = !stall_req_o;
      @(posedge clk_i);
      #1;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      if (done) break;
      if (scramble) begin
        valid_m_i      = 1'($urandom_range(0, 1));
        mem_read_m_i   = 1'($urandom_range(0, 1));
        mem_write_m_i  = 1'($urandom_range(0, 1));
        alu_result_m_i = $urandom();
        write_data_m_i = $urandom();
      end
    end
    check("instr_completes", 32'(done), 32'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        in_txn, granted;
    int          n_stall, n_err;
    logic [68:0] first_cmd, gnt_cmd;
    exp_t        e;
    in_txn = 1'b0;
    granted = 1'b0;
    n_stall = 0;
    n_err = 0;
    first_cmd = '0;
    gnt_cmd = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (reset_i) begin
        in_txn = 1'b0;
        continue;
      end
      if (misalign_o) begin
        if (exp_q.size() == 0) begin
          check("misalign_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("misalign_kind", 32'(e.mis), 32'd1);
          check("misalign_no_req", 32'(bus_req_o), 32'd0);
          check("misalign_no_stall", 32'(stall_req_o), 32'd0);
        end
      end
      if (stall_req_o) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          granted   = 1'b0;
          n_stall   = 0;
          n_err     = 0;
          first_cmd = {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o};
          check("first_cycle_req", 32'(bus_req_o), 32'd1);
        end
        if (bus_req_o && bus_gnt_i) begin
          granted = 1'b1;
          gnt_cmd = {bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o};
        end
        n_stall++;
        if (bus_err_o) n_err++;
      end else if (in_txn) begin
        in_txn = 1'b0;
        if (exp_q.size() == 0) begin
          check("txn_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("txn_kind", 32'(e.mis), 32'd0);
          check("stall_cycles", 32'(n_stall), 32'(e.stalls));
          check("bus_err_pulses", 32'(n_err), 32'(e.err));
          check("bus_we", 32'(first_cmd[68]), 32'(e.we));
          check("bus_addr", first_cmd[67:36], e.addr);
          check("bus_be", 32'(first_cmd[35:32]), 32'(e.be));
          if (e.we) check("bus_wdata", first_cmd[31:0], e.wdata);
          if (granted) check("cmd_stable_to_gnt", 32'(gnt_cmd == first_cmd), 32'd1);
          check("done_no_req", 32'(bus_req_o), 32'd0);
          check("read_data", read_data_m_o, e.rdata);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0] widths [5];

  initial begin
    logic        rd, wr, v;
    logic [2:0]  w;
    logic [31:0] a;
    int          n;
    widths = '{WIDTH_W, WIDTH_H, WIDTH_HU, WIDTH_B, WIDTH_BU};

    // reset with an access pending on the inputs: nothing may reach the bus
    reset_i        = 1'b1;
    valid_m_i      = 1'b1;
    mem_read_m_i   = 1'b0;
    mem_write_m_i  = 1'b1;
    width_src_m_i  = WIDTH_W;
    alu_result_m_i = 32'h10;
    write_data_m_i = 32'h1234_5678;
    bus_gnt_i      = 1'b0;
    bus_rvalid_i   = 1'b0;
    bus_rdata_i    = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_bus_req", 32'(bus_req_o), 32'd0);
    check("rst_bus_we", 32'(bus_we_o), 32'd0);
    check("rst_bus_addr", bus_addr_o, 32'd0);
    check("rst_bus_be", 32'(bus_be_o), 32'd0);
    check("rst_bus_wdata", bus_wdata_o, 32'd0);
    check("rst_stall", 32'(stall_req_o), 32'd0);
    check("rst_read_data", read_data_m_o, 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_bus_err", 32'(bus_err_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    @(posedge clk_i);
    #1;
    reset_i   = 1'b0;
    valid_m_i = 1'b0;

    // directed corner cases
    issue(1'b1, 1'b0, 1'b1, WIDTH_W, 32'h100, 32'hCAFE_BABE, 0, 1, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 1'b0, WIDTH_B, 32'h203, 32'h0, 2, 1, 32'h1122_3344, 1'b0);
    issue(1'b1, 1'b0, 1'b1, WIDTH_H, 32'h102, 32'h0000_BEEF, 1, 1, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 1'b0, WIDTH_W, 32'h101, 32'h0, 0, 1, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 1'b0, WIDTH_W, 32'h300, 32'h0, 0, 10, 32'h5555_AAAA, 1'b0);
    issue(1'b1, 1'b0, 1'b1, WIDTH_B, 32'h007, 32'h0000_00A5, T + 2, 1, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 1'b1, WIDTH_HU, 32'h40E, 32'hFFFF_0000, T, 1, 32'h0BAD_F00D, 1'b0);

    // reset while a read sits in WAIT, then a stale rvalid must be ignored
    valid_m_i      = 1'b1;
    mem_read_m_i   = 1'b1;
    mem_write_m_i  = 1'b0;
    width_src_m_i  = WIDTH_W;
    alu_result_m_i = 32'h400;
    @(negedge clk_i);
    bus_gnt_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus_gnt_i = 1'b0;
    valid_m_i = 1'b0;
    check("pre_reset_state", 32'(state_o), 32'(S_WAIT));
    reset_i = 1'b1;
    @(negedge clk_i);
    check("reset_drops_req", 32'(bus_req_o), 32'd0);
    check("reset_drops_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_i      = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_0000;
    @(negedge clk_i);
    check("post_reset_state", 32'(state_o), 32'(S_IDLE));
    check("post_reset_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    bus_rvalid_i = 1'b0;
    rd_model     = 32'h0;
    @(negedge clk_i);
    check("late_rvalid_ignored", read_data_m_o, 32'd0);
    check("late_rvalid_idle", 32'(state_o), 32'(S_IDLE));
    @(posedge clk_i);
    #1;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      w  = widths[$urandom_range(0, 4)];
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      v  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      a = $urandom();
      n = size_of(w);
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      issue(v, rd, wr, w, a, $urandom(), int'($urandom_range(0, 6)), int'($urandom_range(1, 6)),
            $urandom(), 1'($urandom_range(0, 1)));
    end
    valid_m_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog expired actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
